// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the fetch and execute stages: opcodes, register
// selectors and instruction field positions, so both stages slice identically.
package instr_fetch_stage_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_STO  = 4'h1;
    localparam logic [3:0] OP_IMUL = 4'h2;
    localparam logic [3:0] OP_LED  = 4'h3;

    localparam logic [7:0] R0 = 8'd0;
    localparam logic [7:0] R1 = 8'd1;
    localparam logic [7:0] R2 = 8'd2;
    localparam logic [7:0] R3 = 8'd3;
    localparam logic [7:0] R4 = 8'd4;
    localparam logic [7:0] R5 = 8'd5;
    localparam logic [7:0] R6 = 8'd6;
    localparam logic [7:0] R7 = 8'd7;

    localparam int OP_MSB   = 27;
    localparam int OP_LSB   = 24;
    localparam int DST_MSB  = 23;
    localparam int DST_LSB  = 16;
    localparam int SRC1_MSB = 15;
    localparam int SRC1_LSB = 8;
    localparam int SRC0_MSB = 7;
    localparam int SRC0_LSB = 0;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } fetchState_t;

    function automatic logic [27:0] nopWord();
        return {OP_NOP, 24'h000000};
    endfunction

endpackage

// File: rtl/instr_fetch_stage_pc_counter.sv
// Program counter: redirect beats increment, wraps silently at the top of
// the address space.
module pc_counter #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              increment,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target;
        end else if (increment) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: addresses the combinational ROM, holds one fetched word behind
// a valid/ready handshake and slices it into fields for execute.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSN_W   = 28,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iEnable,
    output logic [ADDR_W-1:0] oRomAddress,
    input  logic [INSN_W-1:0] iRomInstruction,
    output logic              oValid,
    input  logic              iReady,
    output logic [INSN_W-1:0] oInstruction,
    output logic [ADDR_W-1:0] oPC,
    output logic [3:0]        oOpcode,
    output logic [7:0]        oDest,
    output logic [7:0]        oSrc1,
    output logic [7:0]        oSrc0,
    output logic [15:0]       oImm,
    input  logic              iRedirect,
    input  logic [ADDR_W-1:0] iRedirectTarget,
    output logic [15:0]       oStallCount
);

    fetchState_t      state;
    fetchState_t      nextState;
    logic             load;
    logic             transfer;
    logic             stall;
    logic [ADDR_W-1:0] pc;

    pc_counter #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) pcCounter (
        .clk      (Clock),
        .rst_n    (Reset),
        .increment(load),
        .redirect (iRedirect),
        .target   (iRedirectTarget),
        .pc       (pc)
    );

    assign oRomAddress = pc;
    assign oValid      = (state == FULL);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    // Redirect flushes regardless of handshake; a consumer taking the word
    // in the same cycle still sees a completed transfer.
    always_comb begin
        transfer  = 1'b0;
        stall     = 1'b0;
        load      = 1'b0;
        nextState = state;
        transfer  = oValid & iReady;
        stall     = oValid & ~iReady;
        load      = iEnable & (~oValid | iReady) & ~iRedirect;
        if (iRedirect) begin
            nextState = EMPTY;
        end else if (load) begin
            nextState = FULL;
        end else if (transfer) begin
            nextState = EMPTY;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oInstruction <= nopWord();
            oPC          <= '0;
        end else if (load) begin
            oInstruction <= iRomInstruction;
            oPC          <= pc;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oStallCount <= '0;
        end else if (stall && (oStallCount != 16'hFFFF)) begin
            oStallCount <= oStallCount + 16'd1;
        end
    end

    assign oOpcode = oInstruction[OP_MSB:OP_LSB];
    assign oDest   = oInstruction[DST_MSB:DST_LSB];
    assign oSrc1   = oInstruction[SRC1_MSB:SRC1_LSB];
    assign oSrc0   = oInstruction[SRC0_MSB:SRC0_LSB];
    assign oImm    = oInstruction[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios plus random
// handshake/redirect traffic compared against a transaction-level model.
module tb_instr_fetch_stage;
    import instr_fetch_stage_pkg::*;

    logic        Clock;
    logic        Reset;
    logic        iEnable;
    logic [15:0] oRomAddress;
    logic [27:0] iRomInstruction;
    logic        oValid;
    logic        iReady;
    logic [27:0] oInstruction;
    logic [15:0] oPC;
    logic [3:0]  oOpcode;
    logic [7:0]  oDest;
    logic [7:0]  oSrc1;
    logic [7:0]  oSrc0;
    logic [15:0] oImm;
    logic        iRedirect;
    logic [15:0] iRedirectTarget;
    logic [15:0] oStallCount;

    logic [15:0] romAddress2;
    logic [27:0] romInstruction2;
    logic        valid2;
    logic [27:0] instruction2;
    logic [15:0] pc2;
    logic [3:0]  opcode2;
    logic [7:0]  dest2;
    logic [7:0]  src1b;
    logic [7:0]  src0b;
    logic [15:0] imm2;
    logic [15:0] stallCount2;

    int testsRun;
    int testsFailed;

    logic        mValid;
    logic [15:0] mPc;
    logic [27:0] mInstr;
    logic [15:0] mOutPc;
    int          mStall;

    function automatic logic [27:0] romWord(input logic [15:0] addr);
        case (addr)
            16'd0:   return {OP_NOP, 24'h000000};
            16'd1:   return {OP_STO, R1, 16'd60000};
            16'd4:   return {OP_IMUL, R3, R1, R2};
            default: return {addr[15:12] ^ 4'hA, addr[7:0] ^ 8'h3C, addr};
        endcase
    endfunction

    assign iRomInstruction = romWord(oRomAddress);
    assign romInstruction2 = romWord(romAddress2);

    instr_fetch_stage dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .iEnable        (iEnable),
        .oRomAddress    (oRomAddress),
        .iRomInstruction(iRomInstruction),
        .oValid         (oValid),
        .iReady         (iReady),
        .oInstruction   (oInstruction),
        .oPC            (oPC),
        .oOpcode        (oOpcode),
        .oDest          (oDest),
        .oSrc1          (oSrc1),
        .oSrc0          (oSrc0),
        .oImm           (oImm),
        .iRedirect      (iRedirect),
        .iRedirectTarget(iRedirectTarget),
        .oStallCount    (oStallCount)
    );

    instr_fetch_stage #(.RESET_PC(16'hFFFE)) dutWrap (
        .Clock          (Clock),
        .Reset          (Reset),
        .iEnable        (1'b1),
        .oRomAddress    (romAddress2),
        .iRomInstruction(romInstruction2),
        .oValid         (valid2),
        .iReady         (1'b1),
        .oInstruction   (instruction2),
        .oPC            (pc2),
        .oOpcode        (opcode2),
        .oDest          (dest2),
        .oSrc1          (src1b),
        .oSrc0          (src0b),
        .oImm           (imm2),
        .iRedirect      (1'b0),
        .iRedirectTarget(16'h0000),
        .oStallCount    (stallCount2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mValid = 1'b0;
        mPc    = 16'h0000;
        mInstr = {OP_NOP, 24'h000000};
        mOutPc = 16'h0000;
        mStall = 0;
    endtask

    // Asserts reset mid-cycle, checks the reset state, releases on a falling edge.
    task automatic applyReset();
        Reset = 1'b0;
        #1;
        modelReset();
        checkOutput("rstValid", {31'd0, oValid}, 32'd0);
        checkOutput("rstStall", {16'd0, oStallCount}, 32'd0);
        checkOutput("rstRomAddr", {16'd0, oRomAddress}, 32'd0);
        checkOutput("rstPC", {16'd0, oPC}, 32'd0);
        checkOutput("rstOpcode", {28'd0, oOpcode}, {28'd0, OP_NOP});
        checkOutput("rstInsn", {4'd0, oInstruction}, 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    // Drives one cycle of inputs, advances the model and compares after the edge.
    task automatic applyStimulus(input logic en, input logic rdy, input logic redir, input logic [15:0] tgt);
        iEnable         = en;
        iReady          = rdy;
        iRedirect       = redir;
        iRedirectTarget = tgt;
        #1;
        checkOutput("romAddrPre", {16'd0, oRomAddress}, {16'd0, mPc});
        if (mValid && !rdy && mStall < 65535) mStall = mStall + 1;
        if (redir) begin
            mPc    = tgt;
            mValid = 1'b0;
        end else if (en && (!mValid || rdy)) begin
            mInstr = romWord(mPc);
            mOutPc = mPc;
            mPc    = mPc + 16'd1;
            mValid = 1'b1;
        end else if (mValid && rdy) begin
            mValid = 1'b0;
        end
        @(posedge Clock);
        #1;
        checkOutput("valid", {31'd0, oValid}, {31'd0, mValid});
        checkOutput("stallCount", {16'd0, oStallCount}, mStall);
        checkOutput("romAddr", {16'd0, oRomAddress}, {16'd0, mPc});
        if (mValid) begin
            checkOutput("outPC", {16'd0, oPC}, {16'd0, mOutPc});
            checkOutput("insn", {4'd0, oInstruction}, {4'd0, mInstr});
            checkOutput("opcode", {28'd0, oOpcode}, {28'd0, mInstr[27:24]});
            checkOutput("dest", {24'd0, oDest}, {24'd0, mInstr[23:16]});
            checkOutput("src1", {24'd0, oSrc1}, {24'd0, mInstr[15:8]});
            checkOutput("src0", {24'd0, oSrc0}, {24'd0, mInstr[7:0]});
            checkOutput("imm", {16'd0, oImm}, {16'd0, mInstr[15:0]});
        end
    endtask

    initial begin
        logic [15:0] wrapSeq [4];
        logic [15:0] tgt;
        testsRun        = 0;
        testsFailed     = 0;
        Reset           = 1'b1;
        iEnable         = 1'b1;
        iReady          = 1'b1;
        iRedirect       = 1'b0;
        iRedirectTarget = 16'h0000;
        wrapSeq[0] = 16'hFFFE;
        wrapSeq[1] = 16'hFFFF;
        wrapSeq[2] = 16'h0000;
        wrapSeq[3] = 16'h0001;
        @(posedge Clock);
        #1;

        // Free run from reset, with the wrapping instance alongside.
        applyReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
            checkOutput("seqValid", {31'd0, oValid}, 32'd1);
            checkOutput("seqPC", {16'd0, oPC}, i);
            if (i < 4) checkOutput("wrapPC", {16'd0, pc2}, {16'd0, wrapSeq[i]});
        end
        checkOutput("imulOp", {28'd0, oOpcode}, {28'd0, OP_IMUL});
        checkOutput("imulDst", {24'd0, oDest}, {24'd0, R3});
        checkOutput("imulSrc1", {24'd0, oSrc1}, {24'd0, R1});
        checkOutput("imulSrc0", {24'd0, oSrc0}, {24'd0, R2});

        // Three-cycle stall at oPC=1.
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        checkOutput("stoImm", {16'd0, oImm}, 32'd60000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
            checkOutput("stallPC", {16'd0, oPC}, 32'd1);
            checkOutput("stallRom", {16'd0, oRomAddress}, 32'd2);
        end
        checkOutput("stallCnt3", {16'd0, oStallCount}, 32'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        checkOutput("afterStallPC", {16'd0, oPC}, 32'd2);

        // Redirect while stalled, then enable toggling.
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0004);
        checkOutput("redirValid", {31'd0, oValid}, 32'd0);
        checkOutput("redirRom", {16'd0, oRomAddress}, 32'd4);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        checkOutput("redirPC", {16'd0, oPC}, 32'd4);
        checkOutput("redirOp", {28'd0, oOpcode}, {28'd0, OP_IMUL});
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        checkOutput("disValid", {31'd0, oValid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        checkOutput("disRom", {16'd0, oRomAddress}, 32'd5);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        checkOutput("resumePC", {16'd0, oPC}, 32'd5);

        // Reset asserted in the middle of a stall.
        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        checkOutput("midPC", {16'd0, oPC}, 32'd3);
        checkOutput("midStall", {16'd0, oStallCount}, 32'd5);
        applyReset();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            tgt = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 9) == 0, tgt);
        end

        // Saturation of the stall counter.
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        iReady = 1'b0;
        for (int i = 0; i < 66000; i++) @(posedge Clock);
        #1;
        checkOutput("satStall", {16'd0, oStallCount}, 32'hFFFF);
        checkOutput("satPC", {16'd0, oPC}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
